seg7_scan_reader: RTL

- Reading end of the 7-segment interface: observes a multiplexed segment bus and its one-hot digit selects, and recovers the displayed hex digits.
- Each digit is sampled after a settle window, and each segment pattern is decoded back to a nibble.
- Once every digit has been captured, the block presents one frame through a valid/ready handshake.
- Used in self-checking display paths and for readback of segment-driver outputs.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seg7_scan_reader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns and the decoded-digit record for the 7-segment
// readback path. Segment order is bit6..bit0 = g..a, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    // All segments plus dp lit: the driver's lamp-test pattern
    localparam logic [7:0] SEG_LT    = 8'hFF;

    typedef struct packed {
        logic [3:0] hex;
        logic       blank;
        logic       err;
        logic       lt;
        logic       dp;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoder: one 8-bit bus
// pattern in, one decoded digit record out.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [7:0] seg,
    output seg7_dec_t  dec
);

    // Lamp test takes priority; otherwise look the g..a pattern up
    always_comb begin
        dec       = '0;
        dec.dp    = seg[7];
        if (seg == SEG_LT) begin
            dec.hex = 4'h8;
            dec.lt  = 1'b1;
        end else begin
            case (seg[6:0])
                SEG_0:     dec.hex = 4'h0;
                SEG_1:     dec.hex = 4'h1;
                SEG_2:     dec.hex = 4'h2;
                SEG_3:     dec.hex = 4'h3;
                SEG_4:     dec.hex = 4'h4;
                SEG_5:     dec.hex = 4'h5;
                SEG_6:     dec.hex = 4'h6;
                SEG_7:     dec.hex = 4'h7;
                SEG_8:     dec.hex = 4'h8;
                SEG_9:     dec.hex = 4'h9;
                SEG_A:     dec.hex = 4'hA;
                SEG_B:     dec.hex = 4'hB;
                SEG_C:     dec.hex = 4'hC;
                SEG_D:     dec.hex = 4'hD;
                SEG_E:     dec.hex = 4'hE;
                SEG_F:     dec.hex = 4'hF;
                SEG_BLANK: dec.blank = 1'b1;
                default:   dec.err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Watches a multiplexed 7-segment bus, samples each digit once its select
// has been stable for SETTLE cycles, and presents a full frame of decoded
// digits on a valid/ready output.
//
// Output handshake: out_valid with all out_* data is held stable until a
// cycle where out_valid && out_ready; the frame is consumed on that edge.
// A frame completing while the previous one is still unconsumed is dropped
// and flagged by a one-cycle overrun pulse.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [4*NDIG-1:0]   out_hex,
    output logic [NDIG-1:0]     out_blank,
    output logic [NDIG-1:0]     out_dp,
    output logic [NDIG-1:0]     out_err,
    output logic                out_lt,
    output logic                overrun
);

    localparam int           DW       = $clog2(SETTLE + 1);
    localparam logic [DW-1:0] SETTLE_V = DW'(SETTLE);

    seg7_dec_t          dec;
    logic [DW-1:0]      dwell_q, dwell_cur;
    logic [NDIG-1:0]    prev_sel;
    logic [NDIG-1:0]    seen;
    logic [4*NDIG-1:0]  sh_hex;
    logic [NDIG-1:0]    sh_blank, sh_err, sh_dp, sh_lt;
    logic               onehot, sel_change, capture, frame_done;
    logic [4*NDIG-1:0]  frm_hex;
    logic [NDIG-1:0]    frm_blank, frm_err, frm_dp, frm_lt;

    seg7_pattern_decode u_dec (
        .seg (seg),
        .dec (dec)
    );

    // Dwell for the current cycle; a capture fires only on the cycle the
    // count first lands on SETTLE (a fresh select counts as landing too)
    always_comb begin
        onehot     = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
        sel_change = (dig_sel != prev_sel);
        dwell_cur  = '0;
        if (!onehot)
            dwell_cur = '0;
        else if (sel_change)
            dwell_cur = DW'(1);
        else if (dwell_q == SETTLE_V)
            dwell_cur = SETTLE_V;
        else
            dwell_cur = dwell_q + DW'(1);
        capture    = (dwell_cur == SETTLE_V) && (sel_change || (dwell_q != SETTLE_V));
        frame_done = capture && ((seen | dig_sel) == '1);
    end

    // Frame image with the digit being captured this cycle merged in
    always_comb begin
        frm_hex   = sh_hex;
        frm_blank = sh_blank;
        frm_err   = sh_err;
        frm_dp    = sh_dp;
        frm_lt    = sh_lt;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_sel[i]) begin
                frm_hex[4*i +: 4] = dec.hex;
                frm_blank[i]      = dec.blank;
                frm_err[i]        = dec.err;
                frm_dp[i]         = dec.dp;
                frm_lt[i]         = dec.lt;
            end
        end
    end

    // Dwell counter and select history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q  <= '0;
            prev_sel <= '0;
        end else begin
            dwell_q  <= dwell_cur;
            prev_sel <= dig_sel;
        end
    end

    // Shadow capture and seen mask; seen restarts whenever a frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen     <= '0;
            sh_hex   <= '0;
            sh_blank <= '0;
            sh_err   <= '0;
            sh_dp    <= '0;
            sh_lt    <= '0;
        end else if (capture) begin
            sh_hex   <= frm_hex;
            sh_blank <= frm_blank;
            sh_err   <= frm_err;
            sh_dp    <= frm_dp;
            sh_lt    <= frm_lt;
            seen     <= frame_done ? '0 : (seen | dig_sel);
        end
    end

    // Output frame registers, handshake and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_hex   <= '0;
            out_blank <= '0;
            out_dp    <= '0;
            out_err   <= '0;
            out_lt    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_hex   <= frm_hex;
                out_blank <= frm_blank;
                out_dp    <= frm_dp;
                out_err   <= frm_err;
                out_lt    <= |frm_lt;
            end else if (frame_done) begin
                overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
